// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit ALU.
// One registered response slot, tagged with the issuing requester; loads and drains in the same cycle.

module alu_rr_alu_core #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             err
);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_CMP = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ROR = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ROL = OP_W'(4);

    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;
    logic [4:0]     sh;
    logic [5:0]     sh_inv;

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};
    assign sh     = b[4:0];
    // A shift by the full width yields zero, so sh=0 rotates to a unchanged.
    assign sh_inv = 6'd32 - {1'b0, sh};

    always_comb begin
        result = '0;
        flag   = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum_w[WIDTH-1:0];
                flag   = sum_w[WIDTH];
            end
            OP_SUB: begin
                result = diff_w[WIDTH-1:0];
                flag   = diff_w[WIDTH];
            end
            OP_CMP: begin
                result = {{(WIDTH-1){1'b0}}, (a > b)};
                flag   = (a == b);
            end
            OP_ROR: result = (a >> sh) | (a << sh_inv);
            OP_ROL: result = (a << sh) | (a >> sh_inv);
            default: err = 1'b1;
        endcase
    end
endmodule

module alu_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int OP_W      = 3,
    parameter int PRIO_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_flag,
    output logic             rsp_err
);
    localparam int NUM_REQ = 2;

    if (WIDTH != 32) begin : g_bad_width
        $error("alu_rr_arbiter: WIDTH must be 32");
    end
    if (PRIO_INIT != 0 && PRIO_INIT != 1) begin : g_bad_prio
        $error("alu_rr_arbiter: PRIO_INIT must be 0 or 1");
    end

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_req_t;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] result;
        logic             flag;
        logic             err;
    } alu_rsp_t;

    alu_req_t [NUM_REQ-1:0] req;
    logic     [NUM_REQ-1:0] req_valid;
    logic     [NUM_REQ-1:0] req_ready;

    alu_rsp_t rsp_q, rsp_d;
    logic     rsp_valid_q, rsp_valid_d;
    logic     prio_q, prio_d;

    logic             grant_id;
    logic             can_load;
    logic             accept;
    alu_req_t         sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_flag;
    logic             alu_err;

    assign req[0]    = {req0_op, req0_a, req0_b};
    assign req[1]    = {req1_op, req1_a, req1_b};
    assign req_valid = {req1_valid, req0_valid};

    // With both or neither valid the priority holder owns the grant.
    always_comb begin
        grant_id = prio_q;
        if (req_valid == 2'b01)
            grant_id = 1'b0;
        else if (req_valid == 2'b10)
            grant_id = 1'b1;
    end

    assign can_load = ~rsp_valid_q | rsp_ready;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
        assign req_ready[g] = (grant_id == 1'(g)) & can_load & ~rst;
    end

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign accept     = |(req_valid & req_ready);
    assign sel        = req[grant_id];

    alu_rr_alu_core #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_alu (
        .op     (sel.op),
        .a      (sel.a),
        .b      (sel.b),
        .result (alu_result),
        .flag   (alu_flag),
        .err    (alu_err)
    );

    always_comb begin
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        prio_d      = prio_q;
        if (accept) begin
            rsp_d.id     = grant_id;
            rsp_d.result = alu_result;
            rsp_d.flag   = alu_flag;
            rsp_d.err    = alu_err;
            rsp_valid_d  = 1'b1;
            prio_d       = ~grant_id;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            prio_q      <= PRIO_INIT[0];
        end else begin
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            prio_q      <= prio_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_q.id;
    assign rsp_result = rsp_q.result;
    assign rsp_flag   = rsp_q.flag;
    assign rsp_err    = rsp_q.err;
endmodule
